// File: rtl/obj_lbuf_ctrl.sv
// Ping-pong sprite line-buffer controller: draw port writes bank BANK, scan port reads and clears ~BANK.
// Draw write lands 3 cycles after transfer with OBJ_LB_PRIO_EN (PX_RDY low 2 cycles per pixel), else 1 cycle (PX_RDY held 1); scan output 2 cycles after PIX_EN.
module obj_lbuf_ctrl #(
  parameter int XW  = 9,
  parameter int CW  = 8,
  parameter int TPW = 4
) (
  input  logic          CL,
  input  logic          RST_N,
  input  logic          LINE_ST,
  input  logic          PX_VLD,
  output logic          PX_RDY,
  input  logic [XW-1:0] PX_X,
  input  logic [CW-1:0] PX_COL,
  input  logic          PIX_EN,
  input  logic [XW-1:0] HPOS,
  output logic [CW-1:0] OUT_COL,
  output logic          OUT_VLD,
  output logic [XW:0]   LBA_AD,
  output logic          LBA_WE,
  output logic [CW-1:0] LBA_WD,
  input  logic [CW-1:0] LBA_RD,
  output logic [XW:0]   LBB_AD,
  output logic          LBB_WE,
  input  logic [CW-1:0] LBB_RD,
  output logic          BANK
);

  logic px_xfer;
  logic clr_pend;
  logic scan_acc;

  assign px_xfer  = PX_VLD & PX_RDY;
  assign scan_acc = PIX_EN & ~clr_pend;

  always_ff @(posedge CL or negedge RST_N) begin
    if (!RST_N) begin
      BANK <= 1'b0;
    end else begin
      BANK <= BANK ^ LINE_ST;
    end
  end

`ifdef OBJ_LB_PRIO_EN
  typedef enum logic [1:0] {
    S_IDLE,
    S_RD,
    S_CHK
  } state_t;

  state_t        state;
  state_t        state_nxt;
  logic [CW-1:0] col_q;
  logic          wr_ok;

  // The RAM data is only valid in CHK; a cell already holding an opaque pixel is kept.
  assign wr_ok = (state == S_CHK) && (LBA_RD[TPW-1:0] == '0) && (col_q[TPW-1:0] != '0);

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (px_xfer) state_nxt = S_RD;
      S_RD:    state_nxt = S_CHK;
      S_CHK:   state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge CL or negedge RST_N) begin
    if (!RST_N) begin
      state  <= S_IDLE;
      PX_RDY <= 1'b1;
      col_q  <= '0;
      LBA_AD <= '0;
      LBA_WE <= 1'b0;
      LBA_WD <= '0;
    end else begin
      state  <= state_nxt;
      PX_RDY <= (state_nxt == S_IDLE);
      LBA_WE <= wr_ok;
      if (state == S_IDLE && px_xfer) begin
        LBA_AD <= {BANK, PX_X};
        col_q  <= PX_COL;
      end
      if (wr_ok) LBA_WD <= col_q;
    end
  end
`else
  logic opaque;
  logic unused_lba_rd;

  assign opaque        = (PX_COL[TPW-1:0] != '0);
  assign unused_lba_rd = ^LBA_RD;
  assign PX_RDY        = 1'b1;

  always_ff @(posedge CL or negedge RST_N) begin
    if (!RST_N) begin
      LBA_AD <= '0;
      LBA_WE <= 1'b0;
      LBA_WD <= '0;
    end else begin
      LBA_WE <= px_xfer & opaque;
      if (px_xfer && opaque) begin
        LBA_AD <= {BANK, PX_X};
        LBA_WD <= PX_COL;
      end
    end
  end
`endif

  // Read at T+1, clear at T+2 while the read data is captured; the address holds the bank latched at T.
  always_ff @(posedge CL or negedge RST_N) begin
    if (!RST_N) begin
      clr_pend <= 1'b0;
      LBB_AD   <= '0;
      LBB_WE   <= 1'b0;
      OUT_COL  <= '0;
      OUT_VLD  <= 1'b0;
    end else begin
      clr_pend <= scan_acc;
      LBB_WE   <= clr_pend;
      OUT_VLD  <= LBB_WE;
      if (scan_acc) LBB_AD <= {~BANK, HPOS};
      if (LBB_WE) OUT_COL <= LBB_RD;
    end
  end

endmodule

// File: tb/tb_obj_lbuf_ctrl.sv
// Scoreboard bench for obj_lbuf_ctrl with a behavioural two-bank line model and a dual-port RAM.
module tb_obj_lbuf_ctrl;

`ifdef OBJ_LB_PRIO_EN
  localparam int LAT  = 3;
  localparam bit PRIO = 1'b1;
`else
  localparam int LAT  = 1;
  localparam bit PRIO = 1'b0;
`endif

  logic       CL;
  logic       RST_N;
  logic       LINE_ST;
  logic       PX_VLD;
  logic       PX_RDY;
  logic [8:0] PX_X;
  logic [7:0] PX_COL;
  logic       PIX_EN;
  logic [8:0] HPOS;
  logic [7:0] OUT_COL;
  logic       OUT_VLD;
  logic [9:0] LBA_AD;
  logic       LBA_WE;
  logic [7:0] LBA_WD;
  logic [7:0] LBA_RD;
  logic [9:0] LBB_AD;
  logic       LBB_WE;
  logic [7:0] LBB_RD;
  logic       BANK;

  obj_lbuf_ctrl dut (
    .CL(CL), .RST_N(RST_N), .LINE_ST(LINE_ST),
    .PX_VLD(PX_VLD), .PX_RDY(PX_RDY), .PX_X(PX_X), .PX_COL(PX_COL),
    .PIX_EN(PIX_EN), .HPOS(HPOS), .OUT_COL(OUT_COL), .OUT_VLD(OUT_VLD),
    .LBA_AD(LBA_AD), .LBA_WE(LBA_WE), .LBA_WD(LBA_WD), .LBA_RD(LBA_RD),
    .LBB_AD(LBB_AD), .LBB_WE(LBB_WE), .LBB_RD(LBB_RD), .BANK(BANK)
  );

  initial CL = 1'b0;
  always #5 CL = ~CL;

  // Synchronous dual-port RAM, read-before-write, 1-cycle read latency.
  logic [7:0] ram [0:1023];
  always @(posedge CL) begin
    LBA_RD <= ram[LBA_AD];
    LBB_RD <= ram[LBB_AD];
    if (LBA_WE) ram[LBA_AD] <= LBA_WD;
    if (LBB_WE) ram[LBB_AD] <= 8'h00;
  end

  typedef struct {
    logic [9:0] ad;
    logic [7:0] wd;
    int         cyc;
  } wr_t;

  wr_t        wq[$];
  logic [7:0] sq[$];
  logic [9:0] cq[$];

  logic [7:0] model_mem [0:1][0:511];
  bit         tb_bank;
  int         cyc;
  int         ncmp;
  int         nerr;

  always @(posedge CL) cyc <= cyc + 1;

  task automatic chk(input string nm, input longint act, input longint exp);
    ncmp++;
    if (act != exp) begin
      nerr++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Monitor: pops expected responses whenever the DUT presents one.
  always @(negedge CL) begin
    if (LBA_WE) begin
      if (wq.size() == 0) chk("lba_unexpected_we", 1, 0);
      else begin
        wr_t w;
        w = wq.pop_front();
        chk("lba_ad", LBA_AD, w.ad);
        chk("lba_wd", LBA_WD, w.wd);
        chk("lba_we_cycle", cyc, w.cyc);
      end
    end
    if (LBB_WE) begin
      if (cq.size() == 0) chk("lbb_unexpected_we", 1, 0);
      else chk("lbb_clear_ad", LBB_AD, cq.pop_front());
    end
    if (OUT_VLD) begin
      if (sq.size() == 0) chk("out_unexpected_vld", 1, 0);
      else chk("out_col", OUT_COL, sq.pop_front());
    end
  end

  task automatic tick();
    @(posedge CL);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) tick();
  endtask

  task automatic line_st();
    LINE_ST = 1'b1;
    tick();
    LINE_ST = 1'b0;
    tb_bank = ~tb_bank;
  endtask

  // One draw transfer; optionally with LINE_ST in the same cycle.
  task automatic draw(input logic [8:0] x, input logic [7:0] col, input bit ls);
    int  n;
    bit  b;
    bit  wr;
    wr_t w;
    n = 0;
    while (!PX_RDY && n < 10) begin
      tick();
      n++;
    end
    if (!PX_RDY) chk("px_rdy_timeout", 0, 1);
    b = tb_bank;
    PX_VLD  = 1'b1;
    PX_X    = x;
    PX_COL  = col;
    LINE_ST = ls;
    if (PRIO) wr = (col[3:0] != 4'h0) && (model_mem[b][x][3:0] == 4'h0);
    else      wr = (col[3:0] != 4'h0);
    if (wr) begin
      model_mem[b][x] = col;
      w.ad  = {b, x};
      w.wd  = col;
      w.cyc = cyc + LAT;
      wq.push_back(w);
    end
    tick();
    PX_VLD  = 1'b0;
    LINE_ST = 1'b0;
    if (ls) tb_bank = ~tb_bank;
  endtask

  task automatic scan(input logic [8:0] h);
    bit sb;
    sb = ~tb_bank;
    PIX_EN = 1'b1;
    HPOS   = h;
    sq.push_back(model_mem[sb][h]);
    cq.push_back({sb, h});
    model_mem[sb][h] = 8'h00;
    tick();
    PIX_EN = 1'b0;
    tick();
  endtask

  task automatic rand_draw();
    logic [7:0] c;
    c = 8'($urandom);
    if ($urandom_range(0, 3) == 0) c[3:0] = 4'h0;
    draw(9'($urandom_range(0, 15)), c, 1'b0);
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) ram[i] = 8'h00;
    for (int b = 0; b < 2; b++)
      for (int i = 0; i < 512; i++) model_mem[b][i] = 8'h00;
    LBA_RD  = 8'h00;
    LBB_RD  = 8'h00;
    cyc     = 0;
    ncmp    = 0;
    nerr    = 0;
    tb_bank = 1'b0;
    RST_N   = 1'b0;
    LINE_ST = 1'b0;
    PX_VLD  = 1'b0;
    PX_X    = '0;
    PX_COL  = '0;
    PIX_EN  = 1'b0;
    HPOS    = '0;
    repeat (3) @(posedge CL);
    #1 RST_N = 1'b1;

    chk("rst_bank", BANK, 0);
    chk("rst_px_rdy", PX_RDY, 1);
    chk("rst_lba_ad", LBA_AD, 0);
    chk("rst_lba_we", LBA_WE, 0);
    chk("rst_lba_wd", LBA_WD, 0);
    chk("rst_lbb_ad", LBB_AD, 0);
    chk("rst_lbb_we", LBB_WE, 0);
    chk("rst_out_col", OUT_COL, 0);
    chk("rst_out_vld", OUT_VLD, 0);

    // Basic draw then scan of x=5.
    draw(9'd5, 8'h13, 1'b0);
    idle(5);
    line_st();
    chk("bank_after_ls", BANK, tb_bank);
    scan(9'd5);
    idle(4);

    // Two pixels at the same x: priority keeps the first.
    draw(9'd7, 8'h21, 1'b0);
    draw(9'd7, 8'h35, 1'b0);
    idle(5);
    line_st();
    scan(9'd7);
    idle(4);

    // Transparent pixel never writes.
    draw(9'd9, 8'h40, 1'b0);
    idle(5);
    line_st();
    scan(9'd9);
    idle(4);

    // Random draws, full-line scan, then rescan of the same bank reads all zero.
    repeat (30) rand_draw();
    draw(9'd0, 8'h11, 1'b0);
    draw(9'd511, 8'h9F, 1'b0);
    idle(5);
    line_st();
    for (int h = 0; h < 512; h++) scan(9'(h));
    idle(2);
    line_st();
    idle(2);
    line_st();
    for (int h = 0; h < 512; h++) scan(9'(h));
    idle(4);

    // Transfer coincident with LINE_ST lands in the old bank.
    draw(9'd3, 8'h5A, 1'b1);
    chk("bank_after_coincident_ls", BANK, tb_bank);
    idle(5);
    scan(9'd3);
    idle(4);

    // Reset in the read phase of a pixel aborts it.
    PX_VLD = 1'b1;
    PX_X   = 9'd11;
    PX_COL = 8'h77;
    tick();
    PX_VLD = 1'b0;
    RST_N  = 1'b0;
    tick();
    chk("in_rst_px_rdy", PX_RDY, 1);
    chk("in_rst_lba_we", LBA_WE, 0);
    tick();
    RST_N   = 1'b1;
    tb_bank = 1'b0;
    chk("post_rst_bank", BANK, 0);
    chk("post_rst_px_rdy", PX_RDY, 1);
    idle(6);
    line_st();
    scan(9'd11);
    idle(4);

    // Randomized rounds of collision-heavy draws and scans.
    repeat (4) begin
      repeat (20) rand_draw();
      idle(5);
      line_st();
      repeat (16) scan(9'($urandom_range(0, 15)));
      idle(4);
    end

    idle(10);
    chk("final_bank", BANK, tb_bank);
    chk("wq_drained", wq.size(), 0);
    chk("sq_drained", sq.size(), 0);
    chk("cq_drained", cq.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", ncmp, nerr);
    $finish;
  end

endmodule
